// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB arbiter: broadcast payload and source encoding.
package cdb_arbiter_pkg;

  localparam int XLEN     = 32;
  localparam int ROB_ID_W = 4;

  typedef struct packed {
    logic [ROB_ID_W-1:0] idx;
    logic [XLEN-1:0]     val;
  } cdb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } cdb_src_e;

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Per-requester skid FIFO; DEPTH must be a power of two so pointers wrap naturally.
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  cdb_entry_t             wr_entry,
  output cdb_entry_t             head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  cdb_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: only slots between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the CDB between ALU and LSB, each behind a skid FIFO.
// Define CDB_STATS_EN to add the stat_conflict / stat_stall counters.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                jp_wrong,
  input  logic                alu_valid,
  input  logic [ROB_ID_W-1:0] alu_idx,
  input  logic [XLEN-1:0]     alu_val,
  output logic                alu_ready,
  input  logic                lsb_valid,
  input  logic [ROB_ID_W-1:0] lsb_idx,
  input  logic [XLEN-1:0]     lsb_val,
  output logic                lsb_ready,
  output logic                cdb_valid,
  output logic                cdb_src,
  output logic [ROB_ID_W-1:0] cdb_idx,
  output logic [XLEN-1:0]     cdb_val
`ifdef CDB_STATS_EN
  ,
  output logic [31:0]         stat_conflict,
  output logic [31:0]         stat_stall
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  logic [CNT_W-1:0] alu_count, lsb_count;
  cdb_entry_t       alu_head, lsb_head, pop_entry;
  logic             arb_en, alu_push, lsb_push, alu_pop, lsb_pop;
  logic             alu_pending, lsb_pending;
  cdb_src_e         rr_last, winner;

  // Ready comes from the registered count only, so a full FIFO never accepts even if it pops.
  assign alu_ready   = rst && rdy && (alu_count < FULL_COUNT);
  assign lsb_ready   = rst && rdy && (lsb_count < FULL_COUNT);
  assign arb_en      = rdy && !jp_wrong;
  assign alu_push    = alu_valid && alu_ready && arb_en;
  assign lsb_push    = lsb_valid && lsb_ready && arb_en;
  assign alu_pending = (alu_count != '0);
  assign lsb_pending = (lsb_count != '0);

  always_comb begin
    winner = SRC_ALU;
    if (alu_pending && lsb_pending) winner = (rr_last == SRC_ALU) ? SRC_LSB : SRC_ALU;
    else if (lsb_pending)           winner = SRC_LSB;
  end

  assign alu_pop   = arb_en && alu_pending && (winner == SRC_ALU);
  assign lsb_pop   = arb_en && lsb_pending && (winner == SRC_LSB);
  assign pop_entry = (winner == SRC_LSB) ? lsb_head : alu_head;

  cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (jp_wrong),
    .push     (alu_push),
    .pop      (alu_pop),
    .wr_entry ('{idx: alu_idx, val: alu_val}),
    .head     (alu_head),
    .count    (alu_count)
  );

  cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_lsb_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (jp_wrong),
    .push     (lsb_push),
    .pop      (lsb_pop),
    .wr_entry ('{idx: lsb_idx, val: lsb_val}),
    .head     (lsb_head),
    .count    (lsb_count)
  );

  // rr_last starts at LSB so the ALU wins the first tie; it only moves on a real tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid <= 1'b0;
      cdb_src   <= 1'b0;
      cdb_idx   <= '0;
      cdb_val   <= '0;
      rr_last   <= SRC_LSB;
    end else if (jp_wrong) begin
      cdb_valid <= 1'b0;
    end else if (rdy) begin
      if (alu_pop || lsb_pop) begin
        cdb_valid <= 1'b1;
        cdb_src   <= winner;
        cdb_idx   <= pop_entry.idx;
        cdb_val   <= pop_entry.val;
        if (alu_pending && lsb_pending) rr_last <= winner;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

`ifdef CDB_STATS_EN
  logic conflict_evt, stall_evt;

  assign conflict_evt = arb_en && alu_pending && lsb_pending;
  assign stall_evt    = (alu_valid && !alu_ready) || (lsb_valid && !lsb_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_conflict <= '0;
      stat_stall    <= '0;
    end else if (rdy) begin
      if (conflict_evt && (stat_conflict != '1)) stat_conflict <= stat_conflict + 1'b1;
      if (stall_evt && (stat_stall != '1))       stat_stall    <= stat_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed pushes queue expected broadcasts per source,
// a negedge monitor pops and compares every fresh CDB broadcast.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                rdy = 1'b0;
  logic                jp_wrong = 1'b0;
  logic                alu_valid = 1'b0;
  logic [ROB_ID_W-1:0] alu_idx = '0;
  logic [XLEN-1:0]     alu_val = '0;
  logic                alu_ready;
  logic                lsb_valid = 1'b0;
  logic [ROB_ID_W-1:0] lsb_idx = '0;
  logic [XLEN-1:0]     lsb_val = '0;
  logic                lsb_ready;
  logic                cdb_valid;
  logic                cdb_src;
  logic [ROB_ID_W-1:0] cdb_idx;
  logic [XLEN-1:0]     cdb_val;
`ifdef CDB_STATS_EN
  logic [31:0]         stat_conflict;
  logic [31:0]         stat_stall;
`endif

  typedef struct {
    logic [ROB_ID_W-1:0] idx;
    logic [XLEN-1:0]     val;
    int                  cyc;
  } exp_t;

  exp_t sb_alu[$];
  exp_t sb_lsb[$];
  exp_t mon_e;
  bit   mon_have;
  int   checks = 0;
  int   errors = 0;
  int   cyc;
  logic last_rdy;
  int   c;

  cdb_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .jp_wrong  (jp_wrong),
    .alu_valid (alu_valid),
    .alu_idx   (alu_idx),
    .alu_val   (alu_val),
    .alu_ready (alu_ready),
    .lsb_valid (lsb_valid),
    .lsb_idx   (lsb_idx),
    .lsb_val   (lsb_val),
    .lsb_ready (lsb_ready),
    .cdb_valid (cdb_valid),
    .cdb_src   (cdb_src),
    .cdb_idx   (cdb_idx),
    .cdb_val   (cdb_val)
`ifdef CDB_STATS_EN
    ,
    .stat_conflict (stat_conflict),
    .stat_stall    (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // Edge counter and the rdy seen at the last edge, so frozen outputs are not re-consumed.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc      <= 0;
      last_rdy <= 1'b0;
    end else begin
      cyc      <= cyc + 1;
      last_rdy <= rdy;
    end
  end

  always @(negedge clk) begin
    if (rst && last_rdy && cdb_valid) begin
      mon_have = 1'b0;
      if (cdb_src == SRC_LSB) begin
        if (sb_lsb.size() > 0) begin mon_e = sb_lsb.pop_front(); mon_have = 1'b1; end
      end else begin
        if (sb_alu.size() > 0) begin mon_e = sb_alu.pop_front(); mon_have = 1'b1; end
      end
      checks++;
      if (!mon_have) begin
        errors++;
        $display("[TB] FAIL spurious_broadcast src=%0d idx=%0d val=%h cycle=%0d, required no broadcast",
                 cdb_src, cdb_idx, cdb_val, cyc);
      end else if (cdb_idx !== mon_e.idx || cdb_val !== mon_e.val || (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
        errors++;
        $display("[TB] FAIL broadcast_src%0d actual idx=%0d val=%h cycle=%0d required idx=%0d val=%h cycle=%0d",
                 cdb_src, cdb_idx, cdb_val, cyc, mon_e.idx, mon_e.val, mon_e.cyc);
      end
    end
  end

  function automatic logic [XLEN-1:0] mkVal(input logic src, input logic [ROB_ID_W-1:0] idx);
    return {(src ? 16'hB5B5 : 16'hA1A1), 12'h000, idx};
  endfunction

  task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expectBroadcast(input logic src, input logic [ROB_ID_W-1:0] idx,
                                 input logic [XLEN-1:0] val, input int at_cyc);
    exp_t e;
    e.idx = idx;
    e.val = val;
    e.cyc = at_cyc;
    if (src) sb_lsb.push_back(e);
    else     sb_alu.push_back(e);
  endtask

  task automatic applyStimulus(input logic av, input logic [ROB_ID_W-1:0] ai,
                               input logic lv, input logic [ROB_ID_W-1:0] li,
                               input logic jp, input logic r);
    alu_valid = av;
    alu_idx   = ai;
    alu_val   = mkVal(1'b0, ai);
    lsb_valid = lv;
    lsb_idx   = li;
    lsb_val   = mkVal(1'b1, li);
    jp_wrong  = jp;
    rdy       = r;
    @(negedge clk);
  endtask

  // Valid/ready driver: holds each entry until the FIFO accepts it.
  task automatic sendStream(input logic src, input int n, input logic [ROB_ID_W-1:0] first);
    for (int i = 0; i < n; i++) begin
      logic [ROB_ID_W-1:0] id;
      bit                  acc;
      int                  guard;
      id    = first + ROB_ID_W'(i);
      acc   = 1'b0;
      guard = 0;
      expectBroadcast(src, id, mkVal(src, id), -1);
      if (src) begin lsb_valid = 1'b1; lsb_idx = id; lsb_val = mkVal(1'b1, id); end
      else     begin alu_valid = 1'b1; alu_idx = id; alu_val = mkVal(1'b0, id); end
      while (!acc && guard < 50) begin
        #1;
        acc = src ? lsb_ready : alu_ready;
        @(negedge clk);
        guard++;
      end
      if (!acc) checkOutput("stream_accept_timeout", 32'(guard), 32'(0));
    end
    if (src) lsb_valid = 1'b0;
    else     alu_valid = 1'b0;
  endtask

  task automatic drainCheck(input string tag);
    repeat (30) @(negedge clk);
    checkOutput({tag, "_alu_pending"}, 32'(sb_alu.size()), 32'(0));
    checkOutput({tag, "_lsb_pending"}, 32'(sb_lsb.size()), 32'(0));
  endtask

  task automatic resetDut();
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values, then readiness right after release.
    @(negedge clk);
    #1;
    checkOutput("reset_alu_ready", 32'(alu_ready), 32'(0));
    checkOutput("reset_lsb_ready", 32'(lsb_ready), 32'(0));
    checkOutput("reset_cdb_valid", 32'(cdb_valid), 32'(0));
    checkOutput("reset_cdb_src",   32'(cdb_src),   32'(0));
    checkOutput("reset_cdb_idx",   32'(cdb_idx),   32'(0));
    checkOutput("reset_cdb_val",   cdb_val,        32'(0));
    @(negedge clk);
    rdy = 1'b1;
    rst = 1'b1;
    #1;
    checkOutput("release_alu_ready", 32'(alu_ready), 32'(1));
    checkOutput("release_lsb_ready", 32'(lsb_ready), 32'(1));
    checkOutput("release_cdb_valid", 32'(cdb_valid), 32'(0));

    // Single ALU push at cycle 10, visible at cycle 12 for one cycle only.
    while (cyc != 10) @(negedge clk);
    expectBroadcast(1'b0, 4'd3, 32'h0000_00AA, 12);
    alu_valid = 1'b1;
    alu_idx   = 4'd3;
    alu_val   = 32'h0000_00AA;
    @(negedge clk);
    alu_valid = 1'b0;
    #1;
    checkOutput("single_cyc11_valid", 32'(cdb_valid), 32'(0));
    @(negedge clk);
    #1;
    checkOutput("single_cyc12_valid", 32'(cdb_valid), 32'(1));
    @(negedge clk);
    #1;
    checkOutput("single_cyc13_valid", 32'(cdb_valid), 32'(0));
    drainCheck("single");

    // Both sources every cycle: 1,9,2,10,3,11 on consecutive cycles.
    resetDut();
    c = cyc;
    for (int i = 0; i < 3; i++) begin
      expectBroadcast(1'b0, ROB_ID_W'(1 + i), mkVal(1'b0, ROB_ID_W'(1 + i)), c + 2 + 2 * i);
      expectBroadcast(1'b1, ROB_ID_W'(9 + i), mkVal(1'b1, ROB_ID_W'(9 + i)), c + 3 + 2 * i);
      applyStimulus(1'b1, ROB_ID_W'(1 + i), 1'b1, ROB_ID_W'(9 + i), 1'b0, 1'b1);
    end
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    drainCheck("contend");
`ifdef CDB_STATS_EN
    checkOutput("stat_conflict_nonzero", 32'(stat_conflict != 0), 32'(1));
`endif

    // Sustained contention: LSB FIFO fills after 6 LSB pushes, then ALU fills one cycle later.
    resetDut();
    fork
      sendStream(1'b0, 8, 4'd1);
      sendStream(1'b1, 7, 4'd1);
      begin
        repeat (6) @(negedge clk);
        #1;
        checkOutput("full_e6_lsb_ready", 32'(lsb_ready), 32'(0));
        checkOutput("full_e6_alu_ready", 32'(alu_ready), 32'(1));
        @(negedge clk);
        #1;
        checkOutput("full_e7_lsb_ready", 32'(lsb_ready), 32'(1));
        checkOutput("full_e7_alu_ready", 32'(alu_ready), 32'(0));
      end
    join
    drainCheck("full");
`ifdef CDB_STATS_EN
    checkOutput("stat_stall_nonzero", 32'(stat_stall != 0), 32'(1));
`endif

    // Flush: only a1, l1, a2 escape; a fresh tie afterwards goes to LSB (rr_last kept at ALU).
    resetDut();
    c = cyc;
    expectBroadcast(1'b0, 4'd1, mkVal(1'b0, 4'd1), c + 2);
    expectBroadcast(1'b1, 4'd1, mkVal(1'b1, 4'd1), c + 3);
    expectBroadcast(1'b0, 4'd2, mkVal(1'b0, 4'd2), c + 4);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, ROB_ID_W'(i), 1'b1, ROB_ID_W'(i), 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 4'd5, 1'b1, 1'b1);
    #1;
    checkOutput("flush_cdb_valid", 32'(cdb_valid), 32'(0));
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    c = cyc;
    expectBroadcast(1'b1, 4'd12, mkVal(1'b1, 4'd12), c + 2);
    expectBroadcast(1'b0, 4'd12, mkVal(1'b0, 4'd12), c + 3);
    applyStimulus(1'b1, 4'd12, 1'b1, 4'd12, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    drainCheck("flush");

    // Freeze with rdy=0, resume, then async reset mid-stream.
    resetDut();
    c = cyc;
    expectBroadcast(1'b0, 4'd1, mkVal(1'b0, 4'd1), c + 2);
    expectBroadcast(1'b1, 4'd1, mkVal(1'b1, 4'd1), c + 8);
    expectBroadcast(1'b0, 4'd2, mkVal(1'b0, 4'd2), c + 9);
    applyStimulus(1'b1, 4'd1, 1'b1, 4'd1, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'd2, 1'b1, 4'd2, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      #1;
      checkOutput("freeze_cdb_valid", 32'(cdb_valid), 32'(1));
      checkOutput("freeze_cdb_idx",   32'(cdb_idx),   32'(1));
      checkOutput("freeze_alu_ready", 32'(alu_ready), 32'(0));
      checkOutput("freeze_lsb_ready", 32'(lsb_ready), 32'(0));
    end
    rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_cdb_valid", 32'(cdb_valid), 32'(0));
    checkOutput("async_rst_alu_ready", 32'(alu_ready), 32'(0));
    checkOutput("async_rst_alu_pending", 32'(sb_alu.size()), 32'(0));
    checkOutput("async_rst_lsb_pending", 32'(sb_lsb.size()), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single result broadcast bus (CDB) between the ALU and the LSB.
- The bus carries one value per cycle, tagged with a ROB index. The RS, ROB and LSB snoop it to wake up waiting operands.
- Each requester gets a small skid FIFO so both can complete in the same cycle without loss.
- Pending entries drain round-robin. The whole block flushes on a branch mispredict.

Parameters:
- XLEN, 32, data width of a broadcast value.
- ROB_ID_W, 4, width of the ROB index tag.
- FIFO_DEPTH, 4, entries per requester FIFO; power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global run enable; 0 = freeze
- jp_wrong  in  1  mispredict flush
- alu_valid  in  1  ALU result valid
- alu_idx  in  ROB_ID_W  ALU destination ROB index
- alu_val  in  XLEN  ALU result
- alu_ready  out  1  ALU FIFO can accept
- lsb_valid  in  1  LSB result valid
- lsb_idx  in  ROB_ID_W  LSB destination ROB index
- lsb_val  in  XLEN  LSB load result
- lsb_ready  out  1  LSB FIFO can accept
- cdb_valid  out  1  broadcast valid
- cdb_src  out  1  source of broadcast: 0 = ALU, 1 = LSB
- cdb_idx  out  ROB_ID_W  broadcast ROB index
- cdb_val  out  XLEN  broadcast value

Behaviour:
- Reset (rst=0, async):
  - both FIFOs empty; rr_last=1 (ALU wins the first tie).
  - cdb_valid=0, cdb_src=0, cdb_idx=0, cdb_val=0.
  - alu_ready=lsb_ready=0 while in reset, 1 after reset is released.
- Push:
  - accepted when x_valid && x_ready && rdy && !jp_wrong.
  - x_ready = rdy && (count_x < FIFO_DEPTH), driven from a registered count.
  - no pass-through when full: push into a full FIFO is refused even if a pop happens in the same cycle.
- Arbitration (evaluated each cycle when rdy=1 and jp_wrong=0), on FIFO heads only:
  - exactly one FIFO non-empty: pop it.
  - both non-empty: pop the source not equal to rr_last, then set rr_last to the winner.
  - both empty: cdb_valid <= 0.
- Output registers:
  - CDB registers load the popped head; cdb_valid <= 1 when a pop occurs.
  - latency: a push at cycle N into an empty FIFO with no contention appears on the CDB at cycle N+2 (FIFO write at N, pop+register at N+1, visible N+2).
  - each entry is broadcast for exactly one cycle.
- Simultaneous push and pop on the same FIFO: count unchanged; pointers wrap modulo FIFO_DEPTH.
- jp_wrong=1 (synchronous, priority over everything except reset):
  - both FIFOs cleared, pushes in that cycle dropped.
  - cdb_valid <= 0; rr_last unchanged.
- rdy=0:
  - all state and CDB registers hold; x_ready=0.
  - jp_wrong is still honoured when rdy=0.
- Ordering: per source, broadcast order equals push order; no ordering guarantee between ALU and LSB.

Optional Feature:
- Macro: CDB_STATS_EN.
- Defined:
  - adds outputs stat_conflict (32) and stat_stall (32).
  - stat_conflict counts cycles where both FIFOs were non-empty at arbitration.
  - stat_stall counts cycles where x_valid=1 with x_ready=0 for either source (+1 per cycle, not per source).
  - counters reset to 0, saturate at 2^32-1, hold while rdy=0, unaffected by jp_wrong.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package: XLEN, ROB_ID_W, typedef cdb_entry_t {idx, val}, source enum {SRC_ALU=0, SRC_LSB=1}.
- Sub-module cdb_fifo: parameterised on FIFO_DEPTH, push/pop/flush, count output; instantiated twice.

Test Plan:
- Reset release, idle inputs -> cdb_valid=0 and both readys=1 from the first post-reset edge; no spurious broadcast.
- Single ALU push (idx=3, val=0x0000_00AA) at cycle 10 -> cdb_valid=1, src=0, idx=3, val=0xAA at cycle 12 only.
- Both sources push every cycle: ALU idx 1,2,3; LSB idx 9,10,11 -> CDB sequence 1,9,2,10,3,11 (ALU first after reset); no loss; stat_conflict>0 when CDB_STATS_EN is defined.
- LSB pushes 5 back-to-back entries with FIFO_DEPTH=4 while ALU saturates the bus -> lsb_ready=0 after 4 pending entries; LSB holds valid; all 5 LSB idx appear in order.
- 3 ALU entries queued, jp_wrong pulsed for 1 cycle along with a new LSB push -> no broadcast the next cycle; none of the 4 entries ever appear; a fresh push afterwards is broadcast normally.
- rdy=0 for 5 cycles with 2 entries queued and cdb_valid=1 -> CDB outputs frozen, readys=0; after rdy=1 the remaining entry is broadcast; an async rst assertion mid-stream clears cdb_valid immediately.
